// File: rtl/rt_pixel_sink.sv
// rt_pixel_sink
//   Last stage of the ray-tracing pipeline. Finished pixel colours are
//   pushed into an elastic FIFO (no ready towards the shader; the
//   controller is throttled through `stall`). They leave the block as an
//   AXI4-Stream video frame. tuser marks the first pixel of the frame and
//   tlast marks the last pixel of each line. Framing is derived from the
//   output-side x/y counters.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   start              begin a frame (IDLE only, W and H must be non-zero)
//   image_width/height frame geometry, latched on an accepted start
//   in_valid, in_rgb   pixel stream from the shading pipeline
//   stall              freeze request to the controller
//   m_axis_*           AXI4-Stream video output, tdata packed {R,G,B}
//   busy               frame in progress
//   frame_done         one-cycle pulse after the final beat of the frame
//   overflow           sticky: a pixel was dropped or arrived past W*H
module rt_pixel_sink #(
   parameter int COORDINATE_BITS = 12,
   parameter int COLOR_BITS      = 8,
   parameter int FIFO_DEPTH      = 16,
   parameter int STALL_MARGIN    = 6
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       start,
   input  logic [COORDINATE_BITS-1:0] image_width,
   input  logic [COORDINATE_BITS-1:0] image_height,
   input  logic                       in_valid,
   input  logic [3*COLOR_BITS-1:0]    in_rgb,
   output logic                       stall,
   output logic [3*COLOR_BITS-1:0]    m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tuser,
   output logic                       m_axis_tlast,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       overflow
);

   localparam int PIX_W = 3 * COLOR_BITS;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int TOT_W = 2 * COORDINATE_BITS;

   localparam logic [CNT_W-1:0] FULL_LEVEL  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] STALL_LEVEL = CNT_W'(FIFO_DEPTH - STALL_MARGIN);

   typedef enum logic {
      S_IDLE,
      S_ACTIVE
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [PIX_W-1:0]           mem [FIFO_DEPTH];
   logic [PTR_W-1:0]           wr_ptr;
   logic [PTR_W-1:0]           rd_ptr;
   logic [CNT_W-1:0]           count;

   logic [COORDINATE_BITS-1:0] w_q;
   logic [COORDINATE_BITS-1:0] h_q;
   logic [TOT_W-1:0]           total_q;
   logic [COORDINATE_BITS-1:0] w_last;
   logic [COORDINATE_BITS-1:0] h_last;
   logic [COORDINATE_BITS-1:0] x_out;
   logic [COORDINATE_BITS-1:0] y_out;
   logic [TOT_W-1:0]           in_cnt;

   logic active;
   logic start_ok;
   logic pop;
   logic push;
   logic full;
   logic frame_full;
   logic drop;
   logic late;
   logic last_beat;

   assign active     = (state_q == S_ACTIVE);
   assign start_ok   = (state_q == S_IDLE) && start &&
                       (image_width != '0) && (image_height != '0);
   assign full       = (count == FULL_LEVEL);
   assign w_last     = w_q - COORDINATE_BITS'(1);
   assign h_last     = h_q - COORDINATE_BITS'(1);

   assign m_axis_tvalid = active && (count != '0);
   assign pop           = m_axis_tvalid && m_axis_tready;
   // A full FIFO still accepts a pixel when a slot frees in the same cycle.
   assign push          = in_valid && active && (!full || pop);
   assign drop          = in_valid && !push;
   // Every pixel beyond W*H in this frame is flagged, even if it is stored.
   assign frame_full    = (in_cnt == total_q);
   assign late          = in_valid && active && frame_full;
   assign last_beat     = pop && (x_out == w_last) && (y_out == h_last);

   // Read side comes straight from storage: data, and with it the framing,
   // stays put while the consumer holds off.
   assign m_axis_tdata  = mem[rd_ptr];
   assign m_axis_tuser  = m_axis_tvalid && (x_out == '0) && (y_out == '0);
   assign m_axis_tlast  = m_axis_tvalid && (x_out == w_last);

   // Threshold leaves STALL_MARGIN slots for pixels already in the RGU.
   assign stall = (count >= STALL_LEVEL);
   assign busy  = active;

   // ---- state register ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start_ok)  state_d = S_ACTIVE;
         S_ACTIVE: if (last_beat) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // ---- FIFO control, output counters, status flags ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         x_out      <= '0;
         y_out      <= '0;
         in_cnt     <= '0;
         overflow   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= last_beat;

         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase

         if (start_ok) begin
            x_out <= '0;
            y_out <= '0;
         end else if (pop) begin
            if (x_out == w_last) begin
               x_out <= '0;
               y_out <= y_out + COORDINATE_BITS'(1);
            end else begin
               x_out <= x_out + COORDINATE_BITS'(1);
            end
         end

         if (start_ok) begin
            in_cnt <= '0;
         end else if (push && !frame_full) begin
            in_cnt <= in_cnt + TOT_W'(1);
         end

         // A drop on the start edge itself still leaves the flag set.
         if (drop || late) begin
            overflow <= 1'b1;
         end else if (start_ok) begin
            overflow <= 1'b0;
         end
      end
   end

   // ---- pixel storage and frame geometry (data only, no reset) ----
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_rgb;
      end
      if (start_ok) begin
         w_q     <= image_width;
         h_q     <= image_height;
         total_q <= TOT_W'(image_width) * TOT_W'(image_height);
      end
   end

endmodule

// File: tb/tb_rt_pixel_sink.sv
module tb_rt_pixel_sink;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [11:0] image_width;
   logic [11:0] image_height;
   logic        in_valid;
   logic [23:0] in_rgb;
   logic        stall;
   logic [23:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tuser;
   logic        m_axis_tlast;
   logic        busy;
   logic        frame_done;
   logic        overflow;

   int tests = 0;
   int fails = 0;

   rt_pixel_sink #(
      .COORDINATE_BITS(12),
      .COLOR_BITS     (8),
      .FIFO_DEPTH     (16),
      .STALL_MARGIN   (6)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .image_width  (image_width),
      .image_height (image_height),
      .in_valid     (in_valid),
      .in_rgb       (in_rgb),
      .stall        (stall),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tuser (m_axis_tuser),
      .m_axis_tlast (m_axis_tlast),
      .busy         (busy),
      .frame_done   (frame_done),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: frame as a pixel queue ----------------
   logic [23:0] mq[$];
   bit          m_active;
   bit          m_ovf;
   bit          m_fd;
   int          m_W;
   int          m_H;
   int          m_beat;
   int          m_pushed;

   task automatic model_reset();
      mq.delete();
      m_active = 0; m_ovf = 0; m_fd = 0;
      m_W = 1; m_H = 1; m_beat = 0; m_pushed = 0;
   endtask

   task automatic model_check();
      bit ev;
      ev = m_active && (mq.size() != 0);
      chk("busy", 32'(busy), 32'(m_active));
      chk("tvalid", 32'(m_axis_tvalid), 32'(ev));
      if (ev) begin
         chk("tdata", 32'(m_axis_tdata), 32'(mq[0]));
         chk("tuser", 32'(m_axis_tuser), 32'(m_beat == 0));
         chk("tlast", 32'(m_axis_tlast), 32'((m_beat % m_W) == m_W - 1));
      end
      chk("stall", 32'(stall), 32'(mq.size() >= 10));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      chk("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic model_edge();
      bit ev, pp, ps, fd;
      ev = m_active && (mq.size() != 0);
      pp = ev && m_axis_tready;
      ps = in_valid && m_active && ((mq.size() < 16) || pp);
      fd = 0;
      if (m_active) begin
         if (in_valid && (!ps || m_pushed >= m_W * m_H)) m_ovf = 1;
         if (pp) begin
            mq.delete(0);
            if (m_beat == m_W * m_H - 1) begin
               fd = 1;
               m_active = 0;
            end
            m_beat++;
         end
         if (ps) begin
            mq.push_back(in_rgb);
            m_pushed++;
         end
      end else begin
         if (start && image_width != 0 && image_height != 0) begin
            m_active = 1; m_W = int'(image_width); m_H = int'(image_height);
            m_beat = 0; m_pushed = 0; m_ovf = 0;
         end
         if (in_valid) m_ovf = 1;
      end
      m_fd = fd;
   endtask

   // ---------------- cycle driver ----------------
   logic        hold_v, hold_r, hold_u, hold_l;
   logic [23:0] hold_d;
   logic [23:0] obs_data[$];
   logic        obs_user[$];
   logic        obs_last[$];

   task automatic cyc(input logic st, input logic [11:0] w, input logic [11:0] h,
                      input logic iv, input logic [23:0] rgb, input logic rdy);
      @(negedge clk);
      start = st; image_width = w; image_height = h;
      in_valid = iv; in_rgb = rgb; m_axis_tready = rdy;
      #1;
      if (hold_v && !hold_r) begin
         chk("hold_tvalid", 32'(m_axis_tvalid), 32'(1));
         chk("hold_tdata", 32'(m_axis_tdata), 32'(hold_d));
         chk("hold_tuser", 32'(m_axis_tuser), 32'(hold_u));
         chk("hold_tlast", 32'(m_axis_tlast), 32'(hold_l));
      end
      hold_v = m_axis_tvalid; hold_r = rdy;
      hold_d = m_axis_tdata; hold_u = m_axis_tuser; hold_l = m_axis_tlast;
      if (m_axis_tvalid && rdy) begin
         obs_data.push_back(m_axis_tdata);
         obs_user.push_back(m_axis_tuser);
         obs_last.push_back(m_axis_tlast);
      end
      model_check();
      model_edge();
   endtask

   task automatic idle_inputs();
      start = 0; image_width = 0; image_height = 0;
      in_valid = 0; in_rgb = 0; m_axis_tready = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      resetn = 0;
      model_reset();
      hold_v = 0;
      repeat (2) @(negedge clk);
      resetn = 1;
   endtask

   task automatic clear_obs();
      obs_data.delete(); obs_user.delete(); obs_last.delete();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        st;
      logic [11:0] w;
      logic [11:0] h;
      logic        iv;
      logic [23:0] rgb;
      logic        rdy;
      logic        e_busy;
      logic        e_vld;
      logic [23:0] e_data;
      logic        e_user;
      logic        e_last;
      logic        e_fd;
      logic        e_stall;
      logic        e_ovf;
   } vec_t;

   vec_t tbl[15];

   function automatic vec_t mk(logic st, logic [11:0] w, logic [11:0] h, logic iv,
                               logic [23:0] rgb, logic rdy, logic eb, logic ev,
                               logic [23:0] ed, logic eu, logic el, logic ef, logic eo);
      vec_t v;
      v.st = st; v.w = w; v.h = h; v.iv = iv; v.rgb = rgb; v.rdy = rdy;
      v.e_busy = eb; v.e_vld = ev; v.e_data = ed; v.e_user = eu; v.e_last = el;
      v.e_fd = ef; v.e_stall = 1'b0; v.e_ovf = eo;
      return v;
   endfunction

   initial begin
      bit          done;
      logic        iv;
      logic [23:0] px;
      logic [23:0] sent[$];
      int          fw;
      int          fh;
      int          c;

      model_reset();
      hold_v = 0;
      idle_inputs();
      resetn = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
      chk("rst_tuser", 32'(m_axis_tuser), 32'(0));
      chk("rst_tlast", 32'(m_axis_tlast), 32'(0));
      chk("rst_stall", 32'(stall), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_frame_done", 32'(frame_done), 32'(0));
      chk("rst_overflow", 32'(overflow), 32'(0));
      @(negedge clk);
      resetn = 1;

      // W=4,H=2 back-to-back frame, then an ignored W=0 start.
      //             st w  h  iv rgb     rdy busy vld data   usr lst fd ovf
      tbl[0]  = mk(1, 4, 2, 0, 24'h0, 1, 0, 0, 24'h0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 4, 2, 1, 24'h1, 1, 1, 0, 24'h0, 0, 0, 0, 0);
      tbl[2]  = mk(0, 4, 2, 1, 24'h2, 1, 1, 1, 24'h1, 1, 0, 0, 0);
      tbl[3]  = mk(0, 4, 2, 1, 24'h3, 1, 1, 1, 24'h2, 0, 0, 0, 0);
      tbl[4]  = mk(0, 4, 2, 1, 24'h4, 1, 1, 1, 24'h3, 0, 0, 0, 0);
      tbl[5]  = mk(0, 4, 2, 1, 24'h5, 1, 1, 1, 24'h4, 0, 1, 0, 0);
      tbl[6]  = mk(0, 4, 2, 1, 24'h6, 1, 1, 1, 24'h5, 0, 0, 0, 0);
      tbl[7]  = mk(0, 4, 2, 1, 24'h7, 1, 1, 1, 24'h6, 0, 0, 0, 0);
      tbl[8]  = mk(0, 4, 2, 1, 24'h8, 1, 1, 1, 24'h7, 0, 0, 0, 0);
      tbl[9]  = mk(0, 4, 2, 0, 24'h0, 1, 1, 1, 24'h8, 0, 1, 0, 0);
      tbl[10] = mk(0, 4, 2, 0, 24'h0, 1, 0, 0, 24'h0, 0, 0, 1, 0);
      tbl[11] = mk(0, 4, 2, 0, 24'h0, 1, 0, 0, 24'h0, 0, 0, 0, 0);
      tbl[12] = mk(1, 0, 3, 0, 24'h0, 1, 0, 0, 24'h0, 0, 0, 0, 0);
      tbl[13] = mk(0, 0, 3, 1, 24'h55, 1, 0, 0, 24'h0, 0, 0, 0, 0);
      tbl[14] = mk(0, 0, 3, 0, 24'h0, 1, 0, 0, 24'h0, 0, 0, 0, 1);

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         start = tbl[i].st; image_width = tbl[i].w; image_height = tbl[i].h;
         in_valid = tbl[i].iv; in_rgb = tbl[i].rgb; m_axis_tready = tbl[i].rdy;
         #1;
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
         chk($sformatf("vec%0d_tvalid", i), 32'(m_axis_tvalid), 32'(tbl[i].e_vld));
         if (tbl[i].e_vld) begin
            chk($sformatf("vec%0d_tdata", i), 32'(m_axis_tdata), 32'(tbl[i].e_data));
            chk($sformatf("vec%0d_tuser", i), 32'(m_axis_tuser), 32'(tbl[i].e_user));
            chk($sformatf("vec%0d_tlast", i), 32'(m_axis_tlast), 32'(tbl[i].e_last));
         end
         chk($sformatf("vec%0d_frame_done", i), 32'(frame_done), 32'(tbl[i].e_fd));
         chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
         chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
      end

      // Stall threshold and overflow on a full FIFO with the sink blocked.
      do_reset();
      cyc(1, 4, 8, 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 4, 8, 1, 24'(16'h100 + i), 0);
      chk("stall_before_10th_lands", 32'(stall), 32'(0));
      cyc(0, 4, 8, 1, 24'h10a, 0);
      chk("stall_after_10_pushes", 32'(stall), 32'(1));
      for (int i = 11; i < 16; i++) cyc(0, 4, 8, 1, 24'(16'h100 + i), 0);
      cyc(0, 4, 8, 1, 24'hbad, 0);
      chk("full_no_overflow_yet", 32'(overflow), 32'(0));
      cyc(0, 4, 8, 0, 0, 0);
      chk("overflow_on_17th", 32'(overflow), 32'(1));
      clear_obs();
      for (int i = 0; i < 18; i++) cyc(0, 4, 8, 0, 0, 1);
      chk("drain_count", 32'(obs_data.size()), 32'(16));
      if (obs_data.size() == 16) chk("drain_last_data", 32'(obs_data[15]), 32'h10f);

      // Simultaneous push and pop on a full FIFO.
      do_reset();
      cyc(1, 8, 4, 0, 0, 0);
      for (int i = 0; i < 16; i++) cyc(0, 8, 4, 1, 24'(16'h200 + i), 0);
      clear_obs();
      cyc(0, 8, 4, 1, 24'habcdef, 1);
      chk("fullpp_stall", 32'(stall), 32'(1));
      cyc(0, 8, 4, 0, 0, 1);
      chk("fullpp_no_overflow", 32'(overflow), 32'(0));
      chk("fullpp_still_full", 32'(stall), 32'(1));
      for (int i = 0; i < 20; i++) cyc(0, 8, 4, 0, 0, 1);
      chk("fullpp_beats", 32'(obs_data.size()), 32'(17));
      if (obs_data.size() > 16) chk("fullpp_data_16_later", 32'(obs_data[16]), 32'habcdef);

      // Asynchronous reset mid-frame, then a W=2,H=1 frame.
      do_reset();
      cyc(1, 4, 2, 0, 0, 0);
      for (int i = 0; i < 8; i++) cyc(0, 4, 2, 1, 24'(i + 1), 0);
      for (int i = 0; i < 5; i++) cyc(0, 4, 2, 0, 0, 1);
      @(negedge clk);
      idle_inputs();
      m_axis_tready = 1;
      chk("pre_reset_tvalid", 32'(m_axis_tvalid), 32'(1));
      #2;
      resetn = 0;
      #1;
      chk("async_tvalid", 32'(m_axis_tvalid), 32'(0));
      chk("async_tuser", 32'(m_axis_tuser), 32'(0));
      chk("async_tlast", 32'(m_axis_tlast), 32'(0));
      chk("async_busy", 32'(busy), 32'(0));
      chk("async_stall", 32'(stall), 32'(0));
      chk("async_overflow", 32'(overflow), 32'(0));
      chk("async_frame_done", 32'(frame_done), 32'(0));
      model_reset();
      hold_v = 0;
      @(negedge clk);
      resetn = 1;
      clear_obs();
      cyc(1, 2, 1, 0, 0, 1);
      cyc(0, 2, 1, 1, 24'ha1, 1);
      cyc(0, 2, 1, 1, 24'ha2, 1);
      for (int i = 0; i < 4; i++) cyc(0, 2, 1, 0, 0, 1);
      chk("w2h1_beats", 32'(obs_data.size()), 32'(2));
      if (obs_data.size() == 2) begin
         chk("w2h1_b0_tuser", 32'(obs_user[0]), 32'(1));
         chk("w2h1_b0_tlast", 32'(obs_last[0]), 32'(0));
         chk("w2h1_b1_tuser", 32'(obs_user[1]), 32'(0));
         chk("w2h1_b1_tlast", 32'(obs_last[1]), 32'(1));
      end

      // W=3,H=3 with random gaps and 50% tready.
      do_reset();
      clear_obs();
      sent.delete();
      cyc(1, 3, 3, 0, 0, 0);
      done = 0;
      c = 0;
      while (c < 400 && !done) begin
         iv = (sent.size() < 9) && ($urandom_range(0, 3) != 0);
         px = 24'($urandom);
         if (iv) sent.push_back(px);
         cyc(0, 3, 3, iv, px, 1'($urandom_range(0, 1)));
         if (frame_done) done = 1;
         c++;
      end
      chk("rand33_done", 32'(done), 32'(1));
      chk("rand33_beats", 32'(obs_data.size()), 32'(9));
      for (int i = 0; i < 9 && i < obs_data.size(); i++)
         chk($sformatf("rand33_data%0d", i), 32'(obs_data[i]), 32'(sent[i]));

      // Random frames, including W=1 and W=H=1, with surplus input pixels.
      do_reset();
      for (int f = 0; f < 6; f++) begin
         fw = (f == 0) ? 1 : (f == 1) ? 1 : int'($urandom_range(1, 5));
         fh = (f == 0) ? 1 : int'($urandom_range(1, 3));
         cyc(1, 12'(fw), 12'(fh), 0, 0, 1);
         c = 0;
         while (m_active && c < 600) begin
            cyc(0, 12'(fw), 12'(fh), $urandom_range(0, 2) != 0, 24'($urandom),
                1'($urandom_range(0, 1)));
            c++;
         end
         chk($sformatf("frame%0d_completed", f), 32'(m_active), 32'(0));
         cyc(0, 12'(fw), 12'(fh), 0, 0, 0);
         cyc(0, 12'(fw), 12'(fh), 0, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rt_pixel_sink.md
Name: rt_pixel_sink

Overview:
- Downstream stage of the ray-tracing controller and RGU/shading pipeline.
- Collects finished pixel colours into an elastic FIFO and emits them as an AXI4-Stream video frame: tuser marks start-of-frame, tlast marks end-of-line.
- Generates the `stall` that the controller consumes, with enough margin to absorb pixels already in flight in the pipeline.
- Pulses `frame_done` when the final pixel of the frame leaves the block.

Parameters:
- COORDINATE_BITS, 12, width of the image_width/image_height inputs and the internal x/y counters.
- COLOR_BITS, 8, bits per colour channel; tdata is 3*COLOR_BITS wide, packed {R,G,B}.
- FIFO_DEPTH, 16, pixel FIFO entries; must be a power of two and at least STALL_MARGIN+2.
- STALL_MARGIN, 6, free entries reserved for in-flight pixels; must be at least the RGU pipeline depth (5) + 1.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous, active-low.
- start  in  1  begin frame; sampled in IDLE only.
- image_width  in  COORDINATE_BITS  pixels per line; latched on accepted start.
- image_height  in  COORDINATE_BITS  lines per frame; latched on accepted start.
- in_valid  in  1  pixel present on in_rgb this cycle; there is no ready signal.
- in_rgb  in  3*COLOR_BITS  pixel colour.
- stall  out  1  asks upstream to freeze.
- m_axis_tdata  out  3*COLOR_BITS  output pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tuser  out  1  first pixel of frame.
- m_axis_tlast  out  1  last pixel of line.
- busy  out  1  high while in the ACTIVE state.
- frame_done  out  1  one-cycle pulse after the final beat.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset (async, resetn=0):
  - FIFO emptied; count=0; x_out=y_out=0; state=IDLE.
  - Outputs: stall=0, m_axis_tvalid=0, tuser=0, tlast=0, busy=0, frame_done=0, overflow=0. tdata is don't-care.
- Reset asserted mid-frame discards all buffered pixels; no frame_done is issued.
- States: IDLE and ACTIVE.
- IDLE -> ACTIVE on start=1 when image_width!=0 and image_height!=0.
  - On that edge: latch W=image_width and H=image_height, clear x_out/y_out, clear overflow.
  - start with W=0 or H=0 is ignored.
- ACTIVE -> IDLE on the output handshake of beat (x_out=W-1, y_out=H-1).
  - frame_done=1 for exactly the following cycle.
  - start is ignored while ACTIVE.
- Push: every cycle with in_valid=1 writes in_rgb into the FIFO.
  - FIFO full with no pop in the same cycle: pixel is dropped and overflow is set.
  - FIFO full with a pop in the same cycle: push is accepted and count is unchanged.
  - in_valid=1 while IDLE: pixel is dropped and overflow is set.
- Pop: occurs on m_axis_tvalid & m_axis_tready.
  - m_axis_tvalid = (count!=0) & ACTIVE.
  - tdata, tuser and tlast hold stable while tvalid=1 and tready=0.
- Latency: no bypass. A pixel pushed at edge n is visible on tdata no earlier than the cycle after edge n (count!=0 from cycle n+1).
- stall = (count >= FIFO_DEPTH-STALL_MARGIN).
  - Decoded from registered count only; no combinational path from m_axis_tready.
- Framing (computed from the output counters, not the input):
  - tuser = (x_out==0 && y_out==0).
  - tlast = (x_out==W-1).
- Counter update on each pop:
  - x_out==W-1: x_out<=0 and y_out<=y_out+1.
  - Otherwise: x_out<=x_out+1.
  - Arithmetic is COORDINATE_BITS wide; W-1 is compared at the same width.
- W=1: every beat has tlast=1. W=H=1: the single beat has tuser=tlast=1.
- Pixels pushed after the W*H-th are not popped in this frame. They stay in the FIFO, and overflow is set if any arrive once the frame's full pixel count has been pushed.
- busy = (state==ACTIVE).

Test Plan:
- W=4, H=2; 8 pixels 0x000001..0x000008 pushed back-to-back; tready=1 → 8 beats in order; tuser on beat 1 only; tlast on beats 4 and 8; frame_done pulse 1 cycle after beat 8; busy falls with it.
- FIFO_DEPTH=16, STALL_MARGIN=6; tready=0; push 10 pixels → stall=1 in the cycle after the 10th push; 6 further pushes accepted; the 17th is dropped and overflow=1.
- Full FIFO; push and pop in the same cycle → count stays 16; overflow stays 0; the pushed data appears 16 beats later.
- Random tready (50%) during a W=3, H=3 frame → tdata/tuser/tlast never change while tvalid=1 and tready=0; all 9 pixels delivered in order.
- resetn=0 asynchronously mid-frame (after 5 of 8 beats), then a new start with W=2, H=1 → outputs go to their reset values immediately; new frame gives tuser+tlast pattern (1,0), (0,1).
- start with W=0 → state stays IDLE; busy=0; a subsequent in_valid sets overflow.
